// File: rtl/serial_field_unpacker_if.sv
// ---------------------------------------------------------------------------
// serial_field_unpacker_if
//   Handshake bundle between a bit-serial producer, the field unpacker and the
//   downstream word consumer.
//
//   Serial input side : in_bit, in_first, in_valid  (producer -> unpacker)
//                       in_ready                    (unpacker -> producer)
//   Word output side  : out_valid, out_lsb, out_field, out_flag,
//                       out_pad_err, out_sync_err   (unpacker -> consumer)
//                       out_ready                   (consumer -> unpacker)
//
//   master : the environment around the unpacker (drives the serial bits and
//            out_ready).
//   slave  : the unpacker itself.
// ---------------------------------------------------------------------------
interface serial_field_unpacker_if #(
    parameter int FIELD_WIDTH = 3
);
    logic                   in_bit;
    logic                   in_first;
    logic                   in_valid;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_lsb;
    logic [FIELD_WIDTH-1:0] out_field;
    logic                   out_flag;
    logic                   out_pad_err;
    logic                   out_sync_err;

    modport master (
        output in_bit, in_first, in_valid, out_ready,
        input  in_ready, out_valid, out_lsb, out_field, out_flag,
               out_pad_err, out_sync_err
    );

    modport slave (
        input  in_bit, in_first, in_valid, out_ready,
        output in_ready, out_valid, out_lsb, out_field, out_flag,
               out_pad_err, out_sync_err
    );
endinterface

// File: rtl/serial_field_unpacker.sv
// ---------------------------------------------------------------------------
// serial_field_unpacker
//   Reassembles a WORD_WIDTH-bit word from an LSB-first serial stream framed
//   by in_first, splits it into lsb / field / flag / padding, checks that the
//   padding is zero and presents the result under a valid/ready handshake.
//
//   Ports:
//     clk   : clock, all state changes on the rising edge
//     rst_n : synchronous active-low reset
//     bus   : serial_field_unpacker_if.slave
//               in_bit/in_first/in_valid/in_ready  serial input handshake
//               out_valid/out_ready                word output handshake
//               out_lsb      word bit 0
//               out_field    word bits [FIELD_WIDTH:1]
//               out_flag     word bit FIELD_WIDTH+1
//               out_pad_err  any padding bit above the flag was set
//               out_sync_err word was preceded by an aborted partial word
// ---------------------------------------------------------------------------
module serial_field_unpacker #(
    parameter int WORD_WIDTH  = 11,
    parameter int FIELD_WIDTH = 3
) (
    input logic                    clk,
    input logic                    rst_n,
    serial_field_unpacker_if.slave bus
);
    localparam int CW = $clog2(WORD_WIDTH);
    localparam int SW = WORD_WIDTH - 1;
    localparam logic [CW-1:0] LAST_POS = CW'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CW-1:0]          r_count;
    // The top bit is never stored: it arrives on in_bit in the load cycle.
    logic [SW-1:0]          r_shift;
    logic                   r_sync_latch;

    logic                   r_out_valid;
    logic                   r_out_lsb;
    logic [FIELD_WIDTH-1:0] r_out_field;
    logic                   r_out_flag;
    logic                   r_out_pad_err;
    logic                   r_out_sync_err;

    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_start;
    logic                   w_store;
    logic                   w_load;
    logic                   w_resync;
    logic                   w_take;
    logic [WORD_WIDTH-1:0]  w_word;
    logic                   w_pad_err;

    // A new word may begin in the very cycle the held word is taken.
    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Complete word as it will be loaded: stored bits plus the final bit.
    assign w_word = {bus.in_bit, r_shift};

    generate
        if (WORD_WIDTH > FIELD_WIDTH + 2) begin : g_pad
            assign w_pad_err = |w_word[WORD_WIDTH-1:FIELD_WIDTH+2];
        end else begin : g_no_pad
            assign w_pad_err = 1'b0;
        end
    endgenerate

    always_comb begin
        // NOTE: every signal assigned here gets a default first so that no
        // path through the case statement leaves it unassigned (no latches).
        w_state_next = r_state;
        w_start      = 1'b0;
        w_store      = 1'b0;
        w_load       = 1'b0;
        w_resync     = 1'b0;
        w_take       = 1'b0;

        case (r_state)
            IDLE: begin
                // Unframed bits are silently dropped until a word start.
                if (w_accept && bus.in_first) begin
                    w_start      = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_accept) begin
                    if (bus.in_first) begin
                        // Restart wins even on the last position.
                        w_start  = 1'b1;
                        w_resync = 1'b1;
                    end else if (r_count == LAST_POS) begin
                        w_load       = 1'b1;
                        w_state_next = HOLD;
                    end else begin
                        w_store = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    w_take       = 1'b1;
                    w_state_next = IDLE;
                    if (w_accept && bus.in_first) begin
                        w_start      = 1'b1;
                        w_state_next = SHIFT;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            r_state        <= IDLE;
            r_count        <= '0;
            r_shift        <= '0;
            r_sync_latch   <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_lsb      <= 1'b0;
            r_out_field    <= '0;
            r_out_flag     <= 1'b0;
            r_out_pad_err  <= 1'b0;
            r_out_sync_err <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_start) begin
                r_shift <= SW'(bus.in_bit);
                r_count <= CW'(1);
            end

            if (w_store) begin
                r_shift[r_count] <= bus.in_bit;
                r_count          <= r_count + CW'(1);
            end

            if (w_resync) begin
                r_sync_latch <= 1'b1;
            end

            if (w_take) begin
                r_out_valid <= 1'b0;
            end

            if (w_load) begin
                r_out_valid    <= 1'b1;
                r_out_lsb      <= w_word[0];
                r_out_field    <= w_word[FIELD_WIDTH:1];
                r_out_flag     <= w_word[FIELD_WIDTH+1];
                r_out_pad_err  <= w_pad_err;
                r_out_sync_err <= r_sync_latch;
                r_sync_latch   <= 1'b0;
                r_count        <= '0;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_lsb      = r_out_lsb;
    assign bus.out_field    = r_out_field;
    assign bus.out_flag     = r_out_flag;
    assign bus.out_pad_err  = r_out_pad_err;
    assign bus.out_sync_err = r_out_sync_err;

endmodule

// File: tb/tb_serial_field_unpacker.sv
// ---------------------------------------------------------------------------
// tb_serial_field_unpacker
//   Self-checking bench for serial_field_unpacker: directed scenarios with
//   expected words decoded arithmetically, plus a randomized run compared
//   cycle by cycle against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_serial_field_unpacker;
    localparam int WW = 11;
    localparam int FW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    serial_field_unpacker_if #(.FIELD_WIDTH(FW)) bus ();

    serial_field_unpacker #(
        .WORD_WIDTH (WW),
        .FIELD_WIDTH(FW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- reference model ----------------
    bit             m_q[$];
    bit             m_framing;
    bit             m_sync;
    bit             m_valid;
    bit             m_hsync;
    logic [WW-1:0]  m_word;

    always @(posedge clk) begin
        bit ready;
        bit acc;
        int v;
        if (!rst_n) begin
            m_q.delete();
            m_framing = 0;
            m_sync    = 0;
            m_valid   = 0;
            m_hsync   = 0;
            m_word    = '0;
        end else begin
            ready = !m_valid || (bus.out_ready === 1'b1);
            acc   = (bus.in_valid === 1'b1) && ready;
            if (m_valid && bus.out_ready === 1'b1) m_valid = 0;
            if (acc) begin
                if (bus.in_first) begin
                    if (m_framing) m_sync = 1;
                    m_q.delete();
                    m_q.push_back(bus.in_bit);
                    m_framing = 1;
                end else if (m_framing) begin
                    m_q.push_back(bus.in_bit);
                    if (m_q.size() == WW) begin
                        v = 0;
                        for (int i = 0; i < WW; i++) if (m_q[i]) v += (1 << i);
                        m_word    = WW'(v);
                        m_valid   = 1;
                        m_hsync   = m_sync;
                        m_sync    = 0;
                        m_framing = 0;
                        m_q.delete();
                    end
                end
            end
        end
    end

    // Expected {valid, lsb, field, flag, pad_err, sync_err} for a held word.
    function automatic logic [7:0] exp_fields(input logic [WW-1:0] w, input logic sync);
        int v;
        int lsb;
        int field;
        int flag;
        int pad;
        v     = int'(w);
        lsb   = v % 2;
        field = (v / 2) % (1 << FW);
        flag  = (v / (1 << (FW + 1))) % 2;
        pad   = ((v / (1 << (FW + 2))) != 0) ? 1 : 0;
        return {1'b1, lsb[0], field[FW-1:0], flag[0], pad[0], sync};
    endfunction

    function automatic logic [7:0] get_obs();
        return {bus.out_valid, bus.out_lsb, bus.out_field, bus.out_flag,
                bus.out_pad_err, bus.out_sync_err};
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic send_bit(input logic b, input logic first);
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        bus.in_first = first;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_bit   = 1'b0;
    endtask

    task automatic send_word(input logic [WW-1:0] w);
        for (int i = 0; i < WW; i++) send_bit(w[i], i == 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (get_obs() !== 8'h00) $display("FAIL reset_outputs: got %h want %h", get_obs(), 8'h00);
        else n_pass++;
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_discard();
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b1, 1'b0);
            n_total++;
            if (bus.out_valid !== 1'b0) $display("FAIL idle_discard_%0d: out_valid got %b want 0", i, bus.out_valid);
            else n_pass++;
        end
        send_word(11'h000);
        n_total++;
        if (get_obs() !== 8'h80) $display("FAIL idle_zero_word: got %h want %h", get_obs(), 8'h80);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_basic();
        send_word(11'h01B);
        n_total++;
        if (get_obs() !== exp_fields(11'h01B, 1'b0))
            $display("FAIL basic_01B: got %h want %h", get_obs(), exp_fields(11'h01B, 1'b0));
        else n_pass++;
        n_total++;
        if (bus.out_field !== 3'h5) $display("FAIL basic_field: got %h want 5", bus.out_field);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_pad();
        send_word(11'h41E);
        n_total++;
        if (get_obs() !== exp_fields(11'h41E, 1'b0))
            $display("FAIL pad_41E: got %h want %h", get_obs(), exp_fields(11'h41E, 1'b0));
        else n_pass++;
        n_total++;
        if (bus.out_pad_err !== 1'b1) $display("FAIL pad_err: got %b want 1", bus.out_pad_err);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_sync();
        logic [WW-1:0] w;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom % 2), i == 0);
        send_word(11'h003);
        n_total++;
        if (get_obs() !== exp_fields(11'h003, 1'b1))
            $display("FAIL sync_resync: got %h want %h", get_obs(), exp_fields(11'h003, 1'b1));
        else n_pass++;
        @(negedge clk);
        w = WW'($urandom);
        send_word(w);
        n_total++;
        if (get_obs() !== exp_fields(w, 1'b0))
            $display("FAIL sync_clean_after: got %h want %h", get_obs(), exp_fields(w, 1'b0));
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [WW-1:0] w1;
        logic [WW-1:0] w2;
        logic [7:0]    held;
        w1 = WW'($urandom);
        w2 = WW'($urandom);
        bus.out_ready = 1'b0;
        send_word(w1);
        held = exp_fields(w1, 1'b0);
        for (int c = 0; c < 20; c++) begin
            n_total++;
            if ({bus.in_ready, get_obs()} !== {1'b0, held})
                $display("FAIL stall_cycle_%0d: got ready=%b out=%h want ready=0 out=%h",
                         c, bus.in_ready, get_obs(), held);
            else n_pass++;
            bus.in_valid = 1'b1;
            bus.in_bit   = 1'($urandom % 2);
            bus.in_first = 1'($urandom % 2);
            @(negedge clk);
        end
        // Take the held word while the first bit of the next one arrives.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_first  = 1'b1;
        bus.in_bit    = w2[0];
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL stall_release: out_valid got %b want 0", bus.out_valid);
        else n_pass++;
        for (int i = 1; i < WW; i++) send_bit(w2[i], 1'b0);
        n_total++;
        if (get_obs() !== exp_fields(w2, 1'b0))
            $display("FAIL stall_next_word: got %h want %h", get_obs(), exp_fields(w2, 1'b0));
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [WW-1:0] w;
        send_word(11'h7FF);
        @(negedge clk);
        w = WW'($urandom);
        for (int i = 0; i < 6; i++) send_bit(w[i], i == 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_total++;
        if ({bus.in_ready, get_obs()} !== 9'h100)
            $display("FAIL reset_mid_word: got ready=%b out=%h want ready=1 out=00", bus.in_ready, get_obs());
        else n_pass++;
        send_word(w);
        n_total++;
        if (get_obs() !== exp_fields(w, 1'b0))
            $display("FAIL reset_mid_next: got %h want %h", get_obs(), exp_fields(w, 1'b0));
        else n_pass++;
        // Reset while a word is being held.
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_total++;
        if ({bus.in_ready, get_obs()} !== 9'h100)
            $display("FAIL reset_mid_hold: got ready=%b out=%h want ready=1 out=00", bus.in_ready, get_obs());
        else n_pass++;
        bus.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        int g;
        int words;
        g     = 0;
        words = 0;
        for (int c = 0; c < 800; c++) begin
            bus.in_valid  = ($urandom % 4) != 0;
            bus.in_bit    = 1'($urandom % 2);
            bus.in_first  = bus.in_valid && (g == 0 || ($urandom % 30) == 0);
            bus.out_ready = ($urandom % 10) < 7;
            if (bus.in_valid) g = bus.in_first ? 1 : (g + 1) % WW;
            @(negedge clk);
            n_total++;
            if (bus.in_ready !== (!m_valid || bus.out_ready))
                $display("FAIL rand_in_ready_%0d: got %b want %b", c, bus.in_ready, !m_valid || bus.out_ready);
            else n_pass++;
            n_total++;
            if (bus.out_valid !== m_valid)
                $display("FAIL rand_out_valid_%0d: got %b want %b", c, bus.out_valid, m_valid);
            else n_pass++;
            if (m_valid) begin
                words++;
                n_total++;
                if (get_obs() !== exp_fields(m_word, m_hsync))
                    $display("FAIL rand_fields_%0d: got %h want %h", c, get_obs(), exp_fields(m_word, m_hsync));
                else n_pass++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.out_ready = 1'b1;
        n_total++;
        if (words == 0) $display("FAIL rand_activity: got %0d held-word cycles want >0", words);
        else n_pass++;
    endtask

    initial begin
        bus.in_bit    = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_idle_discard();
        test_basic();
        test_pad();
        test_sync();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_field_unpacker.md
Name: serial_field_unpacker

Overview:
- Receive side of the packed-number path: takes a bit-serial, LSB-first stream and reassembles a WORD_WIDTH-bit word.
- Splits the word into its fields: lsb bit, FIELD_WIDTH-bit field, flag bit, zero-padding.
- Checks that the zero-extension padding is actually zero.
- Presents the fields to downstream logic under a valid/ready handshake.

Parameters:
WORD_WIDTH, 11, total packed word width; must be >= FIELD_WIDTH+2
FIELD_WIDTH, 3, width of the middle field (word bits [FIELD_WIDTH:1])

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_bit  input  1  serial data bit
in_first  input  1  marks in_bit as bit 0 of a new word
in_valid  input  1  upstream bit valid
in_ready  output  1  unpacker can accept a bit
out_valid  output  1  assembled word available
out_ready  input  1  downstream accepts word
out_lsb  output  1  word bit 0
out_field  output  FIELD_WIDTH  word bits [FIELD_WIDTH:1]
out_flag  output  1  word bit FIELD_WIDTH+1
out_pad_err  output  1  1 if any bit above FIELD_WIDTH+1 was nonzero
out_sync_err  output  1  1 if this word was preceded by an aborted partial word

Behaviour:
- Reset: reset is synchronous and active-low on rst_n, sampled at rising clk; one clock.
- Reset values: state=IDLE, bit count=0, shift register=0.
  - Outputs: out_valid=0, out_lsb=0, out_field=0, out_flag=0, out_pad_err=0, out_sync_err=0.
  - Sync-error latch = 0; in_ready=1.
- Accept rule: a bit is accepted when in_valid & in_ready.
- in_ready = !out_valid | out_ready. This is a combinational pass-through, so a new word may start in the same cycle the held word is taken.
- States:
  - IDLE: accepted bits with in_first=0 are discarded (no error).
    - Accepted bit with in_first=1: store as bit 0, count=1, go SHIFT.
  - SHIFT: accepted bit with in_first=0 is stored at position count; count increments.
    - Accepted bit with in_first=1: partial word is discarded, bit stored as bit 0, count=1, sync-error latch set.
    - When the accepted bit lands at position WORD_WIDTH-1 (count was WORD_WIDTH-1): next cycle the outputs are loaded, out_valid=1, count=0, state=HOLD.
  - HOLD: out_valid=1; all out_* stable until out_valid & out_ready.
    - On handshake: out_valid drops next cycle unless a new word completes that same edge; go IDLE.
    - If in_first is accepted in the handshake cycle, that bit is stored as bit 0 and the next state is SHIFT.
- Latency: out_valid rises the cycle after the last bit is accepted. Minimum word period is WORD_WIDTH cycles with out_ready=1.
- out_pad_err: OR of word bits [WORD_WIDTH-1:FIELD_WIDTH+2]. Tie it to 0 when WORD_WIDTH == FIELD_WIDTH+2.
- out_sync_err: copy of the sync-error latch at load time; the latch clears on load.
- in_first accepted while count==WORD_WIDTH-1: treat as resync (abort plus sync error), not as completion.
- Reset asserted mid-word or mid-HOLD: partial and held data are lost; all outputs return to reset values on the next edge.
- Out-of-range situations do not occur: count never exceeds WORD_WIDTH-1.
- Outputs are registered; no combinational path from in_bit to out_*.

Test Plan:
- Reset, then send 11'h01B LSB-first (1,1,0,1,1,0,0,0,0,0,0) with in_first on the first bit and out_ready=1 -> one cycle after the 11th bit: out_valid=1, out_lsb=1, out_field=3'h5, out_flag=1, out_pad_err=0, out_sync_err=0.
- Send 11'h41E (padding bit 10 set) -> out_lsb=0, out_field=3'h7, out_flag=1, out_pad_err=1.
- Send 5 bits of a word, then restart with in_first and send 11'h003 -> out_field=3'h1, out_lsb=1, out_sync_err=1. The following clean word reports out_sync_err=0.
- Hold out_ready=0 after a word completes -> in_ready=0, out_* stable for 20 cycles, in_valid bits ignored. Raise out_ready together with in_first plus a valid bit -> bit accepted, next word assembles correctly.
- Bits with in_first=0 while IDLE after reset (e.g. 7 ones) -> discarded, out_valid stays 0. A following framed 11'h000 yields all-zero fields.
- Drop rst_n for one cycle at bit 6 of a word -> out_valid=0, all outputs 0, count 0. The next framed word decodes correctly with out_sync_err=0.
